// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, RV32I opcodes and forward selects.
// Reused by the ID/EX issue logic and by the ALU itself.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'b00000,
        ALU_SUB    = 5'b00001,
        ALU_SLL    = 5'b00010,
        ALU_SLT    = 5'b00011,
        ALU_SLTU   = 5'b00100,
        ALU_XOR    = 5'b00101,
        ALU_SRL    = 5'b00110,
        ALU_SRA    = 5'b00111,
        ALU_OR     = 5'b01000,
        ALU_AND    = 5'b01001,
        ALU_PASS_B = 5'b01010
    } alu_op_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    // funct7[5] means SUB only for register-register ops; for shifts it means arithmetic.
    function automatic alu_op_t alu_arith(input logic [2:0] funct3,
                                          input logic       alt,
                                          input logic       is_reg);
        alu_op_t op;
        case (funct3)
            3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ID-stage decode of an RV32I instruction into ALU op and operand selects.
import alu_pkg::*;

module alu_decoder (
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output alu_op_t    o_alu_op,
    output logic       o_src_a_pc,
    output logic       o_src_b_imm
);

    // Opcode-keyed decode; anything unrecognised behaves like ADD on registers.
    always_comb begin
        o_alu_op    = ALU_ADD;
        o_src_a_pc  = 1'b0;
        o_src_b_imm = 1'b0;
        case (i_opcode)
            OP_R: begin
                o_alu_op = alu_arith(i_funct3, i_funct7_5, 1'b1);
            end
            OP_I: begin
                o_alu_op    = alu_arith(i_funct3, i_funct7_5, 1'b0);
                o_src_b_imm = 1'b1;
            end
            OP_LOAD, OP_STORE, OP_JALR: begin
                o_src_b_imm = 1'b1;
            end
            OP_BRANCH: begin
                o_alu_op = ALU_SUB;
            end
            OP_LUI: begin
                o_alu_op    = ALU_PASS_B;
                o_src_b_imm = 1'b1;
            end
            OP_AUIPC: begin
                o_src_a_pc  = 1'b1;
                o_src_b_imm = 1'b1;
            end
            OP_JAL: begin
                o_alu_op = ALU_ADD;
            end
            default: begin
                o_alu_op = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register for the ALU path plus EX-stage forwarding and operand select.
import alu_pkg::*;

module id_ex_alu_issue #(
    parameter int         XLEN   = 32,
    parameter logic [4:0] NOP_OP = 5'b00000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic            ValidD,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    output logic [4:0]      alu_opE,
    output logic [XLEN-1:0] SrcA,
    output logic [XLEN-1:0] SrcB,
    output logic [XLEN-1:0] WriteDataE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            ValidE
);

    alu_op_t         w_alu_op;
    logic            w_src_a_pc;
    logic            w_src_b_imm;
    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    logic            w_unused_instr;

    logic [4:0]      r_alu_op;
    logic            r_src_a_pc;
    logic            r_src_b_imm;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rd1;
    logic [XLEN-1:0] r_rd2;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic            r_valid;

    // Immediate bits are consumed via ImmExtD, not decoded here.
    assign w_unused_instr = ^{InstrD[31], InstrD[29:25]};

    alu_decoder u_dec (
        .i_opcode    (InstrD[6:0]),
        .i_funct3    (InstrD[14:12]),
        .i_funct7_5  (InstrD[30]),
        .o_alu_op    (w_alu_op),
        .o_src_a_pc  (w_src_a_pc),
        .o_src_b_imm (w_src_b_imm)
    );

    // ID/EX register: flush beats stall, stall holds every field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_op    <= NOP_OP;
            r_src_a_pc  <= 1'b0;
            r_src_b_imm <= 1'b0;
            r_pc        <= '0;
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_imm       <= '0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_valid     <= 1'b0;
        end else if (FlushE) begin
            r_alu_op    <= NOP_OP;
            r_src_a_pc  <= 1'b0;
            r_src_b_imm <= 1'b0;
            r_pc        <= '0;
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_imm       <= '0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_valid     <= 1'b0;
        end else if (!StallE) begin
            r_alu_op    <= w_alu_op;
            r_src_a_pc  <= w_src_a_pc;
            r_src_b_imm <= w_src_b_imm;
            r_pc        <= PCD;
            r_rd1       <= RD1D;
            r_rd2       <= RD2D;
            r_imm       <= ImmExtD;
            r_rs1       <= InstrD[19:15];
            r_rs2       <= InstrD[24:20];
            r_rd        <= InstrD[11:7];
            r_valid     <= ValidD;
        end
    end

    // rs1 forwarding; the unused 11 encoding falls back to the register value.
    always_comb begin
        w_fwd_a = r_rd1;
        case (ForwardAE)
            FWD_REG: w_fwd_a = r_rd1;
            FWD_W:   w_fwd_a = ResultW;
            FWD_M:   w_fwd_a = ALUResultM;
            default: w_fwd_a = r_rd1;
        endcase
    end

    // rs2 forwarding, which also feeds store data.
    always_comb begin
        w_fwd_b = r_rd2;
        case (ForwardBE)
            FWD_REG: w_fwd_b = r_rd2;
            FWD_W:   w_fwd_b = ResultW;
            FWD_M:   w_fwd_b = ALUResultM;
            default: w_fwd_b = r_rd2;
        endcase
    end

    assign alu_opE    = r_alu_op;
    assign SrcA       = r_src_a_pc  ? r_pc  : w_fwd_a;
    assign SrcB       = r_src_b_imm ? r_imm : w_fwd_b;
    assign WriteDataE = w_fwd_b;
    assign Rs1E       = r_rs1;
    assign Rs2E       = r_rs2;
    assign RdE        = r_rd;
    assign ValidE     = r_valid;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: directed instructions, expected EX view queued per cycle.
module tb_id_ex_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] InstrD, PCD, RD1D, RD2D, ImmExtD;
    logic        ValidD, StallE, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ALUResultM, ResultW;
    logic [4:0]  alu_opE;
    logic [31:0] SrcA, SrcB, WriteDataE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        ValidE;

    typedef struct {
        int          id;
        int          cyc;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        v;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    id_ex_alu_issue #(.XLEN(32), .NOP_OP(5'b00000)) dut (
        .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCD(PCD), .RD1D(RD1D), .RD2D(RD2D),
        .ImmExtD(ImmExtD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUResultM(ALUResultM),
        .ResultW(ResultW), .alu_opE(alu_opE), .SrcA(SrcA), .SrcB(SrcB),
        .WriteDataE(WriteDataE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec%0d: got 0x%08h expected 0x%08h", nm, id, act, exp);
        end
    endtask

    // Monitor: pop every entry due this cycle and compare the EX outputs.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e = sb.pop_front();
            if (m_e.cyc < cyc) begin
                n_checks++;
                n_err++;
                $display("FAIL stale vec%0d: due cycle %0d seen at %0d", m_e.id, m_e.cyc, cyc);
            end else begin
                chk("alu_opE",    m_e.id, {27'd0, alu_opE}, {27'd0, m_e.op});
                chk("SrcA",       m_e.id, SrcA,             m_e.a);
                chk("SrcB",       m_e.id, SrcB,             m_e.b);
                chk("WriteDataE", m_e.id, WriteDataE,       m_e.wd);
                chk("RdE",        m_e.id, {27'd0, RdE},     {27'd0, m_e.rd});
                chk("Rs1E",       m_e.id, {27'd0, Rs1E},    {27'd0, m_e.rs1});
                chk("Rs2E",       m_e.id, {27'd0, Rs2E},    {27'd0, m_e.rs2});
                chk("ValidE",     m_e.id, {31'd0, ValidE},  {31'd0, m_e.v});
            end
        end
    end

    // Drive one ID-stage slot, queue its EX view for the next cycle, then set EX forwarding.
    task automatic issue(input int id, input logic [31:0] instr, pc, rd1, rd2, imm,
                         input logic vld, stl, fls, input logic [1:0] fa, fb,
                         input logic [4:0] e_op, input logic [31:0] e_a, e_b, e_wd,
                         input logic [4:0] e_rd, e_rs1, e_rs2, input logic e_v);
        exp_t e;
        InstrD = instr; PCD = pc; RD1D = rd1; RD2D = rd2; ImmExtD = imm;
        ValidD = vld; StallE = stl; FlushE = fls;
        e.id = id; e.cyc = cyc + 1; e.op = e_op; e.a = e_a; e.b = e_b; e.wd = e_wd;
        e.rd = e_rd; e.rs1 = e_rs1; e.rs2 = e_rs2; e.v = e_v;
        sb.push_back(e);
        @(posedge clk);
        #1;
        ForwardAE = fa;
        ForwardBE = fb;
    endtask

    task automatic reset_checks(input int id);
        chk("rst_alu_opE", id, {27'd0, alu_opE}, 32'd0);
        chk("rst_ValidE",  id, {31'd0, ValidE},  32'd0);
        chk("rst_SrcA",    id, SrcA,             32'd0);
        chk("rst_SrcB",    id, SrcB,             32'd0);
        chk("rst_RdE",     id, {27'd0, RdE},     32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        InstrD = 32'h0000_0013; PCD = 32'd0; RD1D = 32'd0; RD2D = 32'd0; ImmExtD = 32'd0;
        ValidD = 1'b0; StallE = 1'b0; FlushE = 1'b0;
        ForwardAE = 2'b00; ForwardBE = 2'b00;
        ALUResultM = 32'h0000_0077; ResultW = 32'h0000_0099;
        #2;
        reset_checks(0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // id, instr, pc, rd1, rd2, imm, vld, stl, fls, fa, fb | op, SrcA, SrcB, WD, rd, rs1, rs2, v
        issue(1, 32'h402081B3, 32'h40, 32'd10, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h01, 32'd10, 32'd3, 32'd3, 5'd3, 5'd1, 5'd2, 1'b1);
        issue(2, 32'h40335293, 32'h44, 32'h80000000, 32'h11, 32'h403, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h07, 32'h80000000, 32'h403, 32'h11, 5'd5, 5'd6, 5'd3, 1'b1);
        issue(3, 32'h123453B7, 32'h48, 32'h55, 32'h66, 32'h12345000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h0A, 32'h55, 32'h12345000, 32'h66, 5'd7, 5'd8, 5'd3, 1'b1);

        // Mid-cycle asynchronous reset, released before the next edge.
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        reset_checks(100);
        rst_n = 1'b1;

        issue(4, 32'h00002217, 32'h100, 32'h5A, 32'h5B, 32'h2000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h00, 32'h100, 32'h2000, 32'h5B, 5'd4, 5'd0, 5'd0, 1'b1);
        issue(5, 32'h00A48433, 32'h104, 32'd5, 32'd6, 32'd0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00,
              5'h00, 32'h77, 32'd6, 32'd6, 5'd8, 5'd9, 5'd10, 1'b1);
        issue(6, 32'h00A48433, 32'h108, 32'd5, 32'd6, 32'd0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01,
              5'h00, 32'h99, 32'h99, 32'h99, 5'd8, 5'd9, 5'd10, 1'b1);
        issue(7, 32'h00A48433, 32'h10C, 32'd5, 32'd6, 32'd0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b11,
              5'h00, 32'd5, 32'd6, 32'd6, 5'd8, 5'd9, 5'd10, 1'b1);
        issue(8, 32'h00A4A423, 32'h110, 32'h1000, 32'h44, 32'd8, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10,
              5'h00, 32'h1000, 32'd8, 32'h77, 5'd8, 5'd9, 5'd10, 1'b1);
        issue(9, 32'h00208063, 32'h114, 32'd7, 32'd9, 32'h20, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h01, 32'd7, 32'd9, 32'd9, 5'd0, 5'd1, 5'd2, 1'b1);
        issue(10, 32'h00335293, 32'h118, 32'h80000000, 32'h11, 32'd3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h06, 32'h80000000, 32'd3, 32'h11, 5'd5, 5'd6, 5'd3, 1'b1);
        issue(11, 32'h00111093, 32'h11C, 32'h21, 32'h31, 32'd1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h02, 32'h21, 32'd1, 32'h31, 5'd1, 5'd2, 5'd1, 1'b1);
        issue(12, 32'h40010093, 32'h120, 32'h21, 32'h31, 32'h400, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h00, 32'h21, 32'h400, 32'h31, 5'd1, 5'd2, 5'd0, 1'b1);
        issue(13, 32'h003130B3, 32'h124, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h04, 32'd1, 32'd2, 32'd2, 5'd1, 5'd2, 5'd3, 1'b1);
        issue(14, 32'h003120B3, 32'h128, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h03, 32'd1, 32'd2, 32'd2, 5'd1, 5'd2, 5'd3, 1'b1);
        issue(15, 32'h00514093, 32'h12C, 32'd1, 32'd2, 32'd5, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h05, 32'd1, 32'd5, 32'd2, 5'd1, 5'd2, 5'd5, 1'b1);
        issue(16, 32'h403150B3, 32'h130, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h07, 32'd1, 32'd2, 32'd2, 5'd1, 5'd2, 5'd3, 1'b1);
        issue(17, 32'h000000EF, 32'h134, 32'd0, 32'h22, 32'h33, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h00, 32'd0, 32'h22, 32'h22, 5'd1, 5'd0, 5'd0, 1'b1);
        issue(18, 32'h00412083, 32'h138, 32'h100, 32'h7, 32'd4, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h00, 32'h100, 32'd4, 32'h7, 5'd1, 5'd2, 5'd4, 1'b1);

        // Stall: the AND entry holds while the ID slot changes; forwarding still re-samples.
        issue(20, 32'h00D675B3, 32'h200, 32'hF0, 32'h3C, 32'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h09, 32'hF0, 32'h3C, 32'h3C, 5'd11, 5'd12, 5'd13, 1'b1);
        issue(21, 32'h402081B3, 32'h204, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00,
              5'h09, 32'hF0, 32'h3C, 32'h3C, 5'd11, 5'd12, 5'd13, 1'b1);
        issue(22, 32'h123453B7, 32'h208, 32'd1, 32'd2, 32'h12345000, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00,
              5'h09, 32'h77, 32'h3C, 32'h3C, 5'd11, 5'd12, 5'd13, 1'b1);
        issue(23, 32'h00000013, 32'h20C, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00,
              5'h09, 32'hF0, 32'h3C, 32'h3C, 5'd11, 5'd12, 5'd13, 1'b1);
        issue(24, 32'h0107E733, 32'h210, 32'h0F, 32'hF0, 32'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h08, 32'h0F, 32'hF0, 32'hF0, 5'd14, 5'd15, 5'd16, 1'b1);

        // Flush wins over a simultaneous stall.
        issue(25, 32'h402081B3, 32'h214, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00,
              5'h00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        issue(26, 32'h00000013, 32'h218, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
              5'h00, 32'd3, 32'd0, 32'd4, 5'd0, 5'd0, 5'd0, 1'b0);

        StallE = 1'b0;
        FlushE = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_alu_issue.md
Name: id_ex_alu_issue

Overview:
Producer side of the EX-stage ALU interface. It decodes the ID-stage RV32I instruction into the 5-bit ALU operation code and holds it, together with the operands, in the ID/EX pipeline register. Stall and flush commands come from the hazard unit. In EX it applies MEM/WB forwarding and operand selection, then drives alu_opE, SrcA and SrcB into the ALU.

Parameters:
XLEN, 32, datapath width
NOP_OP, 5'b00000, alu_op loaded on reset or flush (ADD)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
InstrD  input  32  ID-stage instruction
PCD  input  32  ID-stage PC
RD1D  input  32  register-file read data rs1
RD2D  input  32  register-file read data rs2
ImmExtD  input  32  sign-extended immediate
ValidD  input  1  ID-stage slot holds a real instruction
StallE  input  1  hold ID/EX contents
FlushE  input  1  squash ID/EX (bubble)
ForwardAE  input  2  00 reg, 01 ResultW, 10 ALUResultM
ForwardBE  input  2  same encoding for rs2
ALUResultM  input  32  MEM-stage ALU result
ResultW  input  32  WB-stage writeback value
alu_opE  output  5  ALU operation code
SrcA  output  32  ALU operand A
SrcB  output  32  ALU operand B
WriteDataE  output  32  forwarded rs2, used as store data
Rs1E, Rs2E, RdE  output  5 each  register indices, used by the hazard unit
ValidE  output  1  EX slot valid

Behaviour:
- Decode (combinational, ID stage), keyed on opcode, funct3 and funct7[5]:
  - ADD 00000, SUB 00001, SLL 00010, SLT 00011, SLTU 00100, XOR 00101, SRL 00110, SRA 00111, OR 01000, AND 01001, PASS_B 01010.
  - R-type uses funct7[5] to select SUB/SRA. I-type ALU applies funct7[5] only for the SRAI/SRLI pair; ADDI never decodes to SUB.
  - Load, store and AUIPC decode to ADD. LUI decodes to PASS_B. Branches decode to SUB. JAL, JALR and unrecognised opcodes decode to ADD.
- Operand-select flags decoded in ID and registered with the instruction:
  - ALUSrcA: PC for AUIPC, else rs1.
  - ALUSrcB: immediate for I, S and U types, else rs2.
- ID/EX register, updated on the rising edge of clk. Priority: rst_n low, then FlushE, then StallE, then load.
  - Reset (async, immediate): all registered fields 0, alu_op = NOP_OP, ValidE = 0.
  - FlushE = 1: same values as reset, synchronously. Flush wins over a simultaneous StallE.
  - StallE = 1 and FlushE = 0: every field holds its value.
  - Otherwise: capture all D-stage fields. ValidE = ValidD.
- Latency: an instruction presented in cycle N appears on alu_opE and the EX outputs in cycle N+1.
- EX-stage forwarding (combinational from registered state and M/W inputs):
  - fwdA = mux(ForwardAE: RD1E, ResultW, ALUResultM).
  - ForwardAE = 11 selects RD1E.
  - fwdB follows the same rules using ForwardBE and RD2E.
  - SrcA = ALUSrcAE ? PCE : fwdA.
  - SrcB = ALUSrcBE ? ImmExtE : fwdB.
  - WriteDataE = fwdB in all cases.
- Forwarding is applied only in EX. A held (stalled) entry re-samples the forwarded values every cycle.
- Reset deasserted mid-stream: the first instruction is captured on the first clock edge after release.

Decomposition:
- Shared package alu_pkg:
  - enum alu_op_t holding the eleven 5-bit codes, reused by the ALU.
  - Opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR.
  - Forward-select constants FWD_REG, FWD_W, FWD_M.
- One sub-module: alu_decoder, purely combinational. It maps InstrD to alu_op, ALUSrcA and ALUSrcB.
- The pipeline register and forwarding muxes remain in id_ex_alu_issue.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle -> outputs clear immediately without a clock edge; alu_opE = 00000, ValidE = 0, SrcA = SrcB = 0.
- Decode sweep: apply `sub x3,x1,x2`, then `srai x5,x6,3` (0x40335293), then `lui x7,0x12345`, one per cycle.
  - Cycles N+1 to N+3 give alu_opE = 00001, then 00111, then 01010.
  - On the LUI cycle SrcB = 0x12345000.
- AUIPC: PCD = 0x100, imm = 0x2000 -> SrcA = 0x100, SrcB = 0x2000, alu_opE = 00000.
- Forwarding: RD1E = 5, ALUResultM = 0x77, ResultW = 0x99.
  - ForwardAE = 10 -> SrcA = 0x77.
  - ForwardAE = 01 -> SrcA = 0x99.
  - ForwardBE = 10 on a store -> WriteDataE = 0x77 while SrcB = immediate.
- Stall: StallE = 1 for 3 cycles while InstrD changes -> alu_opE, RdE and ValidE are unchanged. The new instruction is captured on the cycle after release.
- Flush over stall: StallE = 1 and FlushE = 1 together -> next cycle ValidE = 0, alu_opE = 00000, RdE = 0.
